// File: rtl/cnn_pkg.sv
// cnn_pkg: state encoding and geometry helpers shared by the 1x1-conv output buffer reader.
package cnn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   function automatic int num_pixels(input int w, input int h);
      return w * h;
   endfunction

   // A single-pixel map still needs a one-bit address bus.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: 2-entry register FIFO whose head entry is always a flop, so data never depends on ready.
module skid_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0]       cnt_q, cnt_d, rem;
   logic             pop;

   assign valid = cnt_q != 2'd0;
   assign data  = e0_q;
   assign count = cnt_q;

   // rem is the occupancy once this cycle's pop has left; a push lands right behind it.
   always_comb begin
      pop   = valid && ready;
      rem   = cnt_q - 2'(pop);
      cnt_d = rem + 2'(push);
      e0_d  = pop ? e1_q : e0_q;
      e1_d  = e1_q;
      if (push && rem == 2'd0) e0_d = push_data;
      if (push && rem != 2'd0) e1_d = push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/output_buffer_1x1_reader.sv
// output_buffer_1x1_reader: walks the output buffer once per start and streams each pixel vector
// downstream through a 2-entry skid FIFO with credit-based read issue.
module output_buffer_1x1_reader
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int OUT_CHANNELS = 3,
   parameter int IN_WIDTH     = 5,
   parameter int IN_HEIGHT    = 5,
   parameter int NUM_PIXELS   = num_pixels(IN_WIDTH, IN_HEIGHT),
   parameter int ADDR_W       = addr_w(NUM_PIXELS)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   output logic                               busy,
   output logic                               done,
   output logic [ADDR_W-1:0]                  rd_addr,
   output logic                               rd_en,
   input  logic [DATA_WIDTH*OUT_CHANNELS-1:0] rd_data,
   output logic [DATA_WIDTH*OUT_CHANNELS-1:0] o_data,
   output logic                               o_valid,
   input  logic                               o_ready,
   output logic                               o_last
);

   localparam int DW = DATA_WIDTH * OUT_CHANNELS;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic              inflight_q, inflight_d;
   logic              last_q, last_d;
   logic [1:0]        fifo_count, occ;
   logic              pop, is_last;
   logic [DW:0]       head;

   assign busy    = state_q == ST_ISSUE || state_q == ST_DRAIN;
   assign done    = state_q == ST_DONE;
   assign rd_addr = rd_cnt_q;
   assign o_data  = head[DW:1];
   assign o_last  = o_valid && head[0];

   // Credit counts the slot freed by a beat leaving this cycle, so o_ready=1 sustains one read per cycle.
   always_comb begin
      state_d    = state_q;
      rd_cnt_d   = rd_cnt_q;
      rd_en      = 1'b0;
      pop        = o_valid && o_ready;
      occ        = fifo_count - 2'(pop);
      is_last    = rd_cnt_q == LAST_ADDR;
      case (state_q)
         ST_IDLE: begin
            state_d  = start ? ST_ISSUE : ST_IDLE;
            rd_cnt_d = start ? '0 : rd_cnt_q;
         end
         ST_ISSUE: begin
            rd_en    = occ + 2'(inflight_q) < 2'd2;
            state_d  = (rd_en && is_last) ? ST_DRAIN : ST_ISSUE;
            rd_cnt_d = (rd_en && !is_last) ? rd_cnt_q + 1'b1 : rd_cnt_q;
         end
         ST_DRAIN: state_d = (occ == 2'd0 && !inflight_q) ? ST_DONE : ST_DRAIN;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      inflight_d = rd_en;
      last_d     = rd_en && is_last;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rd_cnt_q   <= '0;
         inflight_q <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_cnt_q   <= rd_cnt_d;
         inflight_q <= inflight_d;
         last_q     <= last_d;
      end
   end

   skid_fifo2 #(.WIDTH(DW + 1)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data ({rd_data, last_q}),
      .ready     (o_ready),
      .valid     (o_valid),
      .data      (head),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_output_buffer_1x1_reader.sv
// tb_output_buffer_1x1_reader: directed bench with a stream-level scoreboard for a 5x5x3 map
// and a second 1x1 instance for the single-pixel corner.
module tb_output_buffer_1x1_reader;

   localparam int N = 25;

   logic        clk = 1'b0;
   logic        rst_n, start, o_ready;
   logic        busy, done, rd_en, o_valid, o_last;
   logic [4:0]  rd_addr;
   logic [23:0] rd_data, o_data;

   logic        start1, o_ready1;
   logic        busy1, done1, rd_en1, o_valid1, o_last1;
   logic [0:0]  rd_addr1;
   logic [23:0] rd_data1, o_data1;

   int tests = 0, fails = 0;
   int exp_idx = 0, nreads = 0, ndone = 0;
   int n1_reads = 0, n1_bad_addr = 0;
   logic        stall_q = 1'b0;
   logic [24:0] stall_snap = '0;

   always #5 clk = ~clk;

   output_buffer_1x1_reader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
      .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last)
   );

   output_buffer_1x1_reader #(.IN_WIDTH(1), .IN_HEIGHT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
      .rd_addr(rd_addr1), .rd_en(rd_en1), .rd_data(rd_data1),
      .o_data(o_data1), .o_valid(o_valid1), .o_ready(o_ready1), .o_last(o_last1)
   );

   function automatic logic [23:0] pix(input int p);
      return {8'(p * 3 + 2), 8'(p * 3 + 1), 8'(p * 3)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Buffer models: one-cycle read latency, garbage whenever no read was issued.
   always @(posedge clk) rd_data  <= rd_en  ? pix(int'(rd_addr))  : 24'($urandom);
   always @(posedge clk) rd_data1 <= rd_en1 ? pix(int'(rd_addr1)) : 24'($urandom);

   // Stream scoreboard: pixels must leave in order 0..N-1, reads must walk 0..N-1, never overrun credit.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_idx = 0;
         nreads  = 0;
         stall_q = 1'b0;
      end else begin
         if (rd_en) begin
            check("credit", 32'((nreads - exp_idx - ((o_valid && o_ready) ? 1 : 0)) < 2), 32'd1);
            check("rd_addr", 32'(rd_addr), 32'(nreads));
            nreads++;
         end
         if (stall_q) begin
            check("stall_valid", 32'(o_valid), 32'd1);
            check("stall_hold", 32'({o_data, o_last}), 32'(stall_snap));
         end
         if (o_valid && o_ready) begin
            check("beat_data", 32'(o_data), 32'(pix(exp_idx)));
            check("beat_last", 32'(o_last), 32'(exp_idx == N - 1));
            exp_idx++;
         end
         if (done) begin
            check("done_beats", 32'(exp_idx), 32'(N));
            check("done_reads", 32'(nreads), 32'(N));
            exp_idx = 0;
            nreads  = 0;
            ndone++;
         end
         stall_q    = o_valid && !o_ready;
         stall_snap = {o_data, o_last};
      end
   end

   always @(negedge clk) if (rst_n && rd_en1) begin
      n1_reads++;
      if (rd_addr1 != 1'b0) n1_bad_addr++;
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int k = 0;
      while (!done && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check(name, 32'(done), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},    32'(busy),    32'd0);
      check({tag, "_done"},    32'(done),    32'd0);
      check({tag, "_rd_en"},   32'(rd_en),   32'd0);
      check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
      check({tag, "_o_valid"}, 32'(o_valid), 32'd0);
      check({tag, "_o_last"},  32'(o_last),  32'd0);
      check({tag, "_o_data"},  32'(o_data),  32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, d0;
      rst_n = 1'b0; start = 1'b0; o_ready = 1'b1; start1 = 1'b0; o_ready1 = 1'b1;
      repeat (3) @(posedge clk);
      #1 check_reset_outputs("rst");
      rst_n = 1'b1;

      // Full pass with o_ready held high.
      pulse_start();
      check("busy_after_start", 32'(busy), 32'd1);
      lat = 1;
      while (!o_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("first_valid_latency", 32'(lat), 32'd3);
      for (int p = 0; p < N; p++) begin
         check("stream_valid", 32'(o_valid), 32'd1);
         check("stream_last", 32'(o_last), 32'(p == N - 1));
         if (p == 0) check("beat0_literal", 32'(o_data), 32'h020100);
         if (p == N - 1) check("beat24_literal", 32'(o_data), 32'h4A4948);
         @(posedge clk); #1;
      end
      check("done_after_last", 32'(done), 32'd1);
      check("busy_with_done", 32'(busy), 32'd0);
      check("valid_after_pass", 32'(o_valid), 32'd0);
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);

      // Random backpressure plus an ignored second start.
      d0 = ndone;
      pulse_start();
      for (int k = 0; k < 600 && !done; k++) begin
         o_ready = 1'($urandom_range(0, 1));
         start   = (k == 8);
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("rand_done", 32'(done), 32'd1);
      o_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1 check("rand_single_done", 32'(ndone), 32'(d0 + 1));
      check("rand_idle", 32'(busy), 32'd0);

      // Downstream stalled for 20 cycles after start.
      o_ready = 1'b0;
      pulse_start();
      repeat (20) @(posedge clk);
      #1 check("stall_reads", 32'(nreads), 32'd2);
      check("stall_o_valid", 32'(o_valid), 32'd1);
      check("stall_pixel0", 32'(o_data), 32'h020100);
      check("stall_busy", 32'(busy), 32'd1);
      o_ready = 1'b1;
      wait_done("stall_resume_done", 100);

      // Asynchronous reset mid-pass, then a clean replay.
      pulse_start();
      lat = 0;
      while (!(rd_en && rd_addr == 5'd10) && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("reach_addr10", 32'(rd_en && rd_addr == 5'd10), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async");
      @(posedge clk); #1 rst_n = 1'b1;
      d0 = ndone;
      pulse_start();
      wait_done("replay_done", 100);
      @(posedge clk); #1;
      check("replay_single_done", 32'(ndone), 32'(d0 + 1));

      // Single-pixel map.
      @(posedge clk); #1 start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      lat = 1;
      while (!o_valid1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      check("p1_valid", 32'(o_valid1), 32'd1);
      check("p1_data", 32'(o_data1), 32'h020100);
      check("p1_last", 32'(o_last1), 32'd1);
      @(posedge clk); #1;
      check("p1_done", 32'(done1), 32'd1);
      check("p1_valid_gone", 32'(o_valid1), 32'd0);
      repeat (3) @(posedge clk);
      #1 check("p1_reads", 32'(n1_reads), 32'd1);
      check("p1_addr", 32'(n1_bad_addr), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
